// File: rtl/acq_pkg.sv
// Shared constants, FSM state type and saturating arithmetic for the
// serial code-phase search controller.
package acq_pkg;

   localparam int unsigned CODE_LEN  = 1023;
   localparam int unsigned PHASE_MAX = CODE_LEN - 1;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      DWELL,
      EVAL,
      DONE
   } acq_state_t;

   // Unsigned add clamped to the all-ones value of a w-bit field (w <= 64).
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned w);
      logic [64:0] s;
      logic [64:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << w) - 65'd1;
      return (s > lim) ? lim[63:0] : s[63:0];
   endfunction

endpackage

// File: rtl/acq_search_ctrl_if.sv
// Correlator/CPU-facing signal bundle of the search controller.
interface acq_search_ctrl_if #(
   parameter int unsigned MAG_W = 40
);
   logic signed [31:0] koef;
   logic               start;
   logic               abort;
   logic [MAG_W-1:0]   threshold;
   logic [9:0]         Phase;
   logic               busy;
   logic               done;
   logic               acq_ok;
   logic [9:0]         best_phase;
   logic [MAG_W-1:0]   best_mag;

   modport master (
      output koef, start, abort, threshold,
      input  Phase, busy, done, acq_ok, best_phase, best_mag
   );

   modport slave (
      input  koef, start, abort, threshold,
      output Phase, busy, done, acq_ok, best_phase, best_mag
   );
endinterface

// File: rtl/dump_sync.sv
// Brings the correlator dump clock into CLK_16M and emits a registered
// one-cycle pulse per rising edge of clk_10k.
module dump_sync (
   input  logic CLK_16M,
   input  logic rst,
   input  logic clk_10k,
   output logic dump
);
   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_dump;

   always_ff @(posedge CLK_16M or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_dump <= 1'b0;
      end else begin
         r_meta <= clk_10k;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_dump <= r_sync & ~r_prev;
      end
   end

   assign dump = r_dump;
endmodule

// File: rtl/acq_search_ctrl.sv
// Serial code-phase search: steps Phase, discards stale dumps, sums |koef|
// over a dwell per phase, keeps the earliest peak and compares to threshold.
module acq_search_ctrl
   import acq_pkg::*;
#(
   parameter int unsigned N_DWELL    = 4,
   parameter int unsigned N_DISCARD  = 1,
   parameter int unsigned PHASE_STEP = 1,
   parameter int unsigned MAG_W      = 40
) (
   input  logic                CLK_16M,
   input  logic                rst,
   input  logic                clk_10k,
   acq_search_ctrl_if.slave    bus
);
   acq_state_t       r_state;
   logic [9:0]       r_phase;
   logic [9:0]       r_best_phase;
   logic [MAG_W-1:0] r_best_mag;
   logic [MAG_W-1:0] r_sum;
   logic [MAG_W-1:0] r_thr;
   logic [1:0]       r_disc_cnt;
   logic [4:0]       r_dwell_cnt;
   logic             r_done;
   logic             r_acq_ok;

   logic             w_dump;
   logic [31:0]      w_mag;
   logic [MAG_W-1:0] w_sum_next;
   logic [10:0]      w_phase_next;
   logic             w_last;
   logic             w_new_best;
   logic [MAG_W-1:0] w_best_next;

   dump_sync u_dump_sync (
      .CLK_16M (CLK_16M),
      .rst     (rst),
      .clk_10k (clk_10k),
      .dump    (w_dump)
   );

   // -2^31 has no positive counterpart in 32 bits; clamp it to 2^31-1.
   always_comb begin
      w_mag = bus.koef;
      if (bus.koef[31]) begin
         if (bus.koef == 32'sh8000_0000) w_mag = 32'h7FFF_FFFF;
         else                            w_mag = ~bus.koef + 32'd1;
      end
   end

   assign w_sum_next   = MAG_W'(sat_add(64'(r_sum), 64'(MAG_W'(w_mag)), MAG_W));
   assign w_phase_next = {1'b0, r_phase} + 11'(PHASE_STEP);
   assign w_last       = w_phase_next > 11'(PHASE_MAX);
   assign w_new_best   = r_sum > r_best_mag;
   assign w_best_next  = w_new_best ? r_sum : r_best_mag;

   always_ff @(posedge CLK_16M or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_phase      <= '0;
         r_best_phase <= '0;
         r_best_mag   <= '0;
         r_sum        <= '0;
         r_thr        <= '0;
         r_disc_cnt   <= '0;
         r_dwell_cnt  <= '0;
         r_done       <= 1'b0;
         r_acq_ok     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.abort) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  if (bus.start) begin
                     r_state      <= SETTLE;
                     r_phase      <= '0;
                     r_best_mag   <= '0;
                     r_best_phase <= '0;
                     r_acq_ok     <= 1'b0;
                     r_thr        <= bus.threshold;
                     r_disc_cnt   <= '0;
                  end
               end
               SETTLE: begin
                  if (r_disc_cnt == 2'(N_DISCARD)) begin
                     r_state     <= DWELL;
                     r_sum       <= '0;
                     r_dwell_cnt <= '0;
                  end else if (w_dump) begin
                     r_disc_cnt <= r_disc_cnt + 2'd1;
                  end
               end
               DWELL: begin
                  if (w_dump) begin
                     r_sum       <= w_sum_next;
                     r_dwell_cnt <= r_dwell_cnt + 5'd1;
                     if (r_dwell_cnt == 5'(N_DWELL - 1)) r_state <= EVAL;
                  end
               end
               EVAL: begin
                  if (w_new_best) begin
                     r_best_mag   <= r_sum;
                     r_best_phase <= r_phase;
                  end
                  // acq_ok must see the peak including this phase's sum.
                  if (w_last) begin
                     r_state  <= DONE;
                     r_done   <= 1'b1;
                     r_acq_ok <= w_best_next > r_thr;
                  end else begin
                     r_phase    <= w_phase_next[9:0];
                     r_disc_cnt <= '0;
                     r_state    <= SETTLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.Phase      = r_phase;
   assign bus.busy       = (r_state != IDLE) && (r_state != DONE);
   assign bus.done       = r_done;
   assign bus.acq_ok     = r_acq_ok;
   assign bus.best_phase = r_best_phase;
   assign bus.best_mag   = r_best_mag;
endmodule
